// File: rtl/struct_rec_packer_pkg.sv
// Shared record definitions for the byte-stream record assembler and its consumers.
// Consumers import rec_t from here rather than redeclaring it.
package rec_pkg;

    localparam int N_A       = 6;
    localparam int REC_BYTES = N_A + 2;

    typedef struct packed {
        bit [N_A-1:0][7:0] a;
        bit [15:0]         b;
    } rec_t;

endpackage

// File: rtl/struct_rec_packer.sv
// Assembles N_A+2 stream bytes (or a shorter frame closed by in_last) into a packed
// rec_t and holds it in a one-entry valid/ready output register.
module struct_rec_packer
    import rec_pkg::*;
#(
    parameter int N_A = rec_pkg::N_A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output rec_t       out_data,
    output logic       out_short,
    output logic [3:0] out_nbytes
);

    // The byte counter is 4 bits wide and rec_t is sized by the package.
    if (N_A + 2 > 15) begin : g_width_check
        $error("struct_rec_packer: N_A+2 must not exceed 15");
    end
    if (N_A != rec_pkg::N_A) begin : g_pkg_check
        $error("struct_rec_packer: N_A must match rec_pkg::N_A");
    end

    typedef enum logic [0:0] {FILL, HOLD} state_t;

    state_t     state;
    logic [3:0] cnt;
    rec_t       asm_buf;
    rec_t       filled;
    logic       accept;
    logic       consume;
    logic       closing;

    assign in_ready = !rst && ((state == FILL) || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign closing  = accept && (in_last || (cnt == 4'(REC_BYTES - 1)));

    // The buffer is zero at frame start, so unfilled slots stay zero in a short record.
    always_comb begin
        filled = asm_buf;
        if (cnt == 4'd0) begin
            filled.b[15:8] = in_data;
        end else if (cnt == 4'd1) begin
            filled.b[7:0] = in_data;
        end else begin
            for (int k = 0; k < N_A; k++) begin
                if (cnt == 4'(k + 2)) begin
                    filled.a[k] = in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            cnt        <= 4'd0;
            asm_buf    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_short  <= 1'b0;
            out_nbytes <= 4'd0;
        end else begin
            if (consume) begin
                state     <= FILL;
                out_valid <= 1'b0;
            end
            // A byte arriving while the held record is consumed starts the next frame.
            if (accept) begin
                if (closing) begin
                    asm_buf    <= '0;
                    cnt        <= 4'd0;
                    out_data   <= filled;
                    out_short  <= (cnt < 4'(REC_BYTES - 1));
                    out_nbytes <= cnt + 4'd1;
                    state      <= HOLD;
                    out_valid  <= 1'b1;
                end else begin
                    asm_buf <= filled;
                    cnt     <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_struct_rec_packer.sv
// Scoreboard bench for struct_rec_packer: directed frames push expected records,
// a negedge monitor pops and compares every record the DUT hands off.
module tb_struct_rec_packer;
    import rec_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    rec_t       out_data;
    logic       out_short;
    logic [3:0] out_nbytes;

    typedef struct {
        logic [63:0] data;
        logic        short_f;
        logic [3:0]  nbytes;
    } exp_t;

    exp_t sb[$];
    int   consume_cyc[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    struct_rec_packer #(.N_A(N_A)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_short (out_short),
        .out_nbytes(out_nbytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every handshake on the output pops one expected record.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            consume_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_record", 64'(out_data), 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 64'(out_data), e.data);
                check("out_short", 64'(out_short), 64'(e.short_f));
                check("out_nbytes", 64'(out_nbytes), 64'(e.nbytes));
            end
        end
    end

    task automatic expect_rec(input logic [63:0] d, input logic s, input logic [3:0] n);
        exp_t e;
        e.data = d; e.short_f = s; e.nbytes = n;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("in_ready_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input logic last_on_end);
        foreach (bytes[i]) send_byte(bytes[i], last_on_end && (i == bytes.size() - 1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_short"}, 64'(out_short), 64'd0);
        check({tag, "_out_nbytes"}, 64'(out_nbytes), 64'd0);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [63:0] held;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full frame closed by in_last on the final byte.
        fr = '{8'hFF, 8'hFC, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00, 8'h42};
        expect_rec(64'h4200_0012_3400_FFFC, 1'b0, 4'd8);
        send_frame(fr, 1'b1);
        drain();

        // Short frame, then a full frame without in_last to prove no residue.
        fr = '{8'hFF, 8'hFC, 8'h00, 8'h34};
        expect_rec(64'h0000_0000_3400_FFFC, 1'b1, 4'd4);
        send_frame(fr, 1'b1);
        fr = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
        expect_rec(64'h1111_1111_1111_1111, 1'b0, 4'd8);
        send_frame(fr, 1'b0);
        drain();

        // Back-pressure: record held for five cycles while a byte waits.
        out_ready = 1'b0;
        held = 64'h8070_6050_4030_1020;
        fr = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        expect_rec(held, 1'b0, 4'd8);
        send_frame(fr, 1'b0);
        in_valid = 1'b1; in_data = 8'hA1; in_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_data_stable", 64'(out_data), held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        fr = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        expect_rec(64'hA8A7_A6A5_A4A3_A1A2, 1'b0, 4'd8);
        send_frame(fr, 1'b0);
        drain();

        // Back-to-back frames: records must be exactly eight cycles apart.
        consume_cyc.delete();
        fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        expect_rec(64'h0807_0605_0403_0102, 1'b0, 4'd8);
        expect_rec(64'h100F_0E0D_0C0B_090A, 1'b0, 4'd8);
        send_frame(fr, 1'b0);
        drain();
        check("b2b_record_count", 64'(consume_cyc.size()), 64'd2);
        if (consume_cyc.size() == 2)
            check("b2b_spacing", 64'(consume_cyc[1] - consume_cyc[0]), 64'd8);

        // Reset mid-frame discards the partial bytes.
        fr = '{8'hEE, 8'hDD, 8'hCC};
        send_frame(fr, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_rec(64'h0807_0605_0403_0102, 1'b0, 4'd8);
        send_frame(fr, 1'b0);
        drain();

        // Single-byte frame.
        fr = '{8'hAB};
        expect_rec(64'h0000_0000_0000_AB00, 1'b1, 4'd1);
        send_frame(fr, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
